// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcode fields, fetch FSM states, fetch payload.
package cpu_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned IMEM_AW_DEFAULT = 12;
   localparam int unsigned OPC_W           = 6;
   localparam int unsigned JTGT_W          = 26;

   localparam logic [OPC_W-1:0] OP_J             = 6'b000010;
   localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;

   // Instruction handed to decode together with its byte address
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_pkt_t;

   // Major opcode field [31:26]
   function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
      return instr[31:26];
   endfunction

   // Jump word-target field [25:0]
   function automatic logic [JTGT_W-1:0] jtarget_of(input logic [XLEN-1:0] instr);
      return instr[25:0];
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: folds unconditional jumps in fetch, otherwise sequential.
module fetch_next_pc
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   output logic [31:0] next_pc_c,
   output logic        is_jump_c
);

   // Jump target keeps the current 256 MiB region; otherwise pc + 4 with wrap
   always_comb begin
      is_jump_c = (opcode_of(instr) == OP_J);
      next_pc_c = pc + 32'd4;
      if (is_jump_c) begin
         next_pc_c = {pc[31:28], jtarget_of(instr), 2'b00};
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, drives IMEM, and presents {instr, pc} to decode
// through a valid/ready output register. Out-of-range PCs park the unit in FAULT
// until a redirect arrives.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned IMEM_AW  = IMEM_AW_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fault,
   output logic [31:0] fetch_count
);

   localparam int unsigned RANGE_SHIFT = IMEM_AW + 2;

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         valid_q, valid_d;
   fetch_pkt_t   pkt_q, pkt_d;
   logic         fault_q, fault_d;
   logic [31:0]  count_q, count_d;

   logic [31:0]  next_pc_c;
   logic         unused_is_jump_c;
   logic         slot_free_c;
   logic         in_range_c;
   logic         load_c;
   logic         accept_c;

   fetch_next_pc u_next_pc (
      .pc        (pc_q),
      .instr     (imem_instr),
      .next_pc_c (next_pc_c),
      .is_jump_c (unused_is_jump_c)
   );

   // Load qualification; out_ready only matters while an instruction is held
   always_comb begin
      slot_free_c = ~valid_q | out_ready;
      in_range_c  = ((pc_q >> RANGE_SHIFT) == 32'd0);
      accept_c    = valid_q & out_ready;
      load_c      = (state_q == RUN) & slot_free_c & in_range_c & ~redirect_valid;
   end

   // Next-state: redirect wins, then load / drain / fault detection
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      pkt_d   = pkt_q;
      fault_d = fault_q;
      count_d = count_q;

      if (redirect_valid) begin
         // Held instruction is squashed and not counted even if decode took it
         valid_d = 1'b0;
         pc_d    = {redirect_pc[31:2], 2'b00};
         state_d = RUN;
         fault_d = 1'b0;
      end else begin
         if (accept_c) begin
            count_d = count_q + 32'd1;
         end
         if (load_c) begin
            pkt_d.instr = imem_instr;
            pkt_d.pc    = pc_q;
            valid_d     = 1'b1;
            pc_d        = next_pc_c;
         end else begin
            if (accept_c) begin
               valid_d = 1'b0;
            end
            if ((state_q == RUN) && slot_free_c && !in_range_c) begin
               state_d = FAULT;
               fault_d = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         pkt_q   <= '0;
         fault_q <= 1'b0;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         pkt_q   <= pkt_d;
         fault_q <= fault_d;
         count_q <= count_d;
      end
   end

   // Outputs come straight from flops
   assign imem_addr   = pc_q;
   assign out_valid   = valid_q;
   assign out_instr   = pkt_q.instr;
   assign out_pc      = pkt_q.pc;
   assign fault       = fault_q;
   assign fetch_count = count_q;

endmodule
